// File: rtl/subband_ram_pkg.sv
// Shared constants for the subband RAM scheduler: channel indices, subband bases, widths.
// Also holds the round-robin index step used by the read arbiter.
package subband_ram_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    localparam int CH_LL = 0;
    localparam int CH_HL = 1;
    localparam int CH_LH = 2;

    localparam logic [11:0] LL_BASE_DEF = 12'd0;
    localparam logic [11:0] HL_BASE_DEF = 12'd32;
    localparam logic [11:0] LH_BASE_DEF = 12'd2048;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/subband_ram_scheduler_rr.sv
// Three-way round-robin arbiter; grant is combinational from req when enabled.
// The pointer moves past the winner only on an actual grant, so a blocked cycle keeps fairness.
module rr_arbiter3
    import subband_ram_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req_i,
    input  logic       en_i,
    output logic [2:0] gnt_o
);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        win   = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int i = 0; i < 3; i++) begin
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
            idx = rr_next(idx);
        end
        if (en_i && found) begin
            gnt_o[win] = 1'b1;
            ptr_d      = rr_next(win);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/subband_ram_scheduler.sv
// Shares one single-port subband RAM between the wavelet writer and LL/HL/LH readers.
// Grants are same-cycle; read data returns one cycle later with a one-hot valid strobe.
module subband_ram_scheduler
    import subband_ram_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter int                DATA_W       = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] LL_BASE      = LL_BASE_DEF,
    parameter logic [ADDR_W-1:0] HL_BASE      = HL_BASE_DEF,
    parameter logic [ADDR_W-1:0] LH_BASE      = LH_BASE_DEF,
    parameter int                STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic [2:0]        rd_req,
    input  logic [ADDR_W-1:0] rd_offset_ll,
    input  logic [ADDR_W-1:0] rd_offset_hl,
    input  logic [ADDR_W-1:0] rd_offset_lh,
    output logic [2:0]        rd_gnt,
    output logic [2:0]        rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]  starve_cnt_q;
    logic [CNT_W-1:0]  starve_cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        rd_valid_q;
    logic              rd_any;
    logic              force_read;
    logic              arb_en;

    assign rd_any     = |rd_req;
    assign force_read = (starve_cnt_q == CNT_MAX) && rd_any;
    assign wr_gnt     = wr_req && !force_read && !rst;
    assign arb_en     = !wr_gnt && !rst;

    rr_arbiter3 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (rd_req),
        .en_i  (arb_en),
        .gnt_o (rd_gnt)
    );

    // Subband address wraps modulo the RAM size by plain truncation.
    always_comb begin
        rd_addr = '0;
        if (rd_gnt[CH_LL]) rd_addr = LL_BASE + rd_offset_ll;
        if (rd_gnt[CH_HL]) rd_addr = HL_BASE + rd_offset_hl;
        if (rd_gnt[CH_LH]) rd_addr = LH_BASE + rd_offset_lh;
    end

    always_comb begin
        if (wr_gnt) begin
            ram_address = wr_addr;
        end else if (|rd_gnt) begin
            ram_address = rd_addr;
        end else begin
            ram_address = addr_q;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if ((|rd_gnt) || !rd_any) begin
            starve_cnt_d = '0;
        end else if (wr_gnt && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
            addr_q       <= '0;
            rd_valid_q   <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= ram_address;
            rd_valid_q   <= rd_gnt;
        end
    end

    // Masking with rst drops a return already in flight when reset lands.
    assign rd_valid = rd_valid_q & {3{~rst}};
    assign rd_data  = ram_q;
    assign ram_data = wr_data;
    assign ram_wren = wr_gnt;

endmodule

// File: tb/tb_subband_ram_scheduler.sv
// Directed bench for subband_ram_scheduler with a registered-address RAM model.
module tb_subband_ram_scheduler;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt;
    logic [2:0]    rd_req;
    logic [AW-1:0] rd_offset_ll;
    logic [AW-1:0] rd_offset_hl;
    logic [AW-1:0] rd_offset_lh;
    logic [2:0]    rd_gnt;
    logic [2:0]    rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [DW-1:0] ram_q;

    logic [DW-1:0] mem [0:4095];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    subband_ram_scheduler #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .LL_BASE      (12'd0),
        .HL_BASE      (12'd32),
        .LH_BASE      (12'd2048),
        .STARVE_LIMIT (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_gnt       (wr_gnt),
        .rd_req       (rd_req),
        .rd_offset_ll (rd_offset_ll),
        .rd_offset_hl (rd_offset_hl),
        .rd_offset_lh (rd_offset_lh),
        .rd_gnt       (rd_gnt),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .ram_address  (ram_address),
        .ram_data     (ram_data),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q)
    );

    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; wr_req = 1'b1; wr_addr = 12'h3FF; wr_data = 16'hBEEF; rd_req = 3'b111;
        rd_offset_ll = '0; rd_offset_hl = '0; rd_offset_lh = '0;
        tick; settle;
        checks++; if (wr_gnt !== 1'b0) begin errors++; $display("FAIL rst_wr_gnt got %b exp 0", wr_gnt); end
        checks++; if (rd_gnt !== 3'b000) begin errors++; $display("FAIL rst_rd_gnt got %b exp 000", rd_gnt); end
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL rst_wren got %b exp 0", ram_wren); end
        checks++; if (rd_valid !== 3'b000) begin errors++; $display("FAIL rst_rd_valid got %b exp 000", rd_valid); end
        checks++; if (ram_address !== 12'h000) begin errors++; $display("FAIL rst_addr got %h exp 000", ram_address); end
        tick; rst = 1'b0; wr_req = 1'b0; rd_req = 3'b000; settle;
        for (int c = 0; c < 3; c++) begin
            checks++; if (wr_gnt !== 1'b0 || ram_wren !== 1'b0) begin errors++; $display("FAIL idle_wr got gnt=%b wren=%b exp 0/0", wr_gnt, ram_wren); end
            checks++; if (rd_gnt !== 3'b000 || rd_valid !== 3'b000) begin errors++; $display("FAIL idle_rd got gnt=%b valid=%b exp 000/000", rd_gnt, rd_valid); end
            checks++; if (ram_address !== 12'h000) begin errors++; $display("FAIL idle_addr got %h exp 000", ram_address); end
            tick; settle;
        end
    endtask

    task automatic test_ll_read;
        rd_offset_ll = 12'h005; rd_req = 3'b001; settle;
        checks++; if (rd_gnt !== 3'b001) begin errors++; $display("FAIL ll_gnt got %b exp 001", rd_gnt); end
        checks++; if (ram_address !== 12'h005) begin errors++; $display("FAIL ll_addr got %h exp 005", ram_address); end
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL ll_wren got %b exp 0", ram_wren); end
        tick; rd_req = 3'b000; settle;
        checks++; if (rd_valid !== 3'b001) begin errors++; $display("FAIL ll_valid got %b exp 001", rd_valid); end
        checks++; if (rd_data !== 16'hD005) begin errors++; $display("FAIL ll_data got %h exp D005", rd_data); end
        checks++; if (ram_address !== 12'h005) begin errors++; $display("FAIL ll_hold_addr got %h exp 005", ram_address); end
        tick; settle;
        checks++; if (rd_valid !== 3'b000) begin errors++; $display("FAIL ll_valid_drop got %b exp 000", rd_valid); end
    endtask

    task automatic test_lh_wrap;
        rd_offset_hl = 12'h003; rd_req = 3'b010; settle;
        checks++; if (rd_gnt !== 3'b010 || ram_address !== 12'h023) begin errors++; $display("FAIL hl_gnt got %b/%h exp 010/023", rd_gnt, ram_address); end
        tick; rd_req = 3'b000; settle;
        checks++; if (rd_valid !== 3'b010 || rd_data !== 16'hD023) begin errors++; $display("FAIL hl_ret got %b/%h exp 010/D023", rd_valid, rd_data); end
        tick; rd_offset_lh = 12'h805; rd_req = 3'b100; settle;
        checks++; if (rd_gnt !== 3'b100) begin errors++; $display("FAIL lh_gnt got %b exp 100", rd_gnt); end
        checks++; if (ram_address !== 12'h005) begin errors++; $display("FAIL lh_wrap_addr got %h exp 005", ram_address); end
        tick; rd_req = 3'b000; settle;
        checks++; if (rd_valid !== 3'b100) begin errors++; $display("FAIL lh_valid got %b exp 100", rd_valid); end
        checks++; if (rd_data !== 16'hD005) begin errors++; $display("FAIL lh_data got %h exp D005", rd_data); end
    endtask

    task automatic test_round_robin;
        logic [2:0]  exp_g [0:2];
        logic [11:0] exp_a [0:2];
        logic [15:0] exp_d [0:2];
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
        exp_a[0] = 12'h001; exp_a[1] = 12'h022; exp_a[2] = 12'h803;
        exp_d[0] = 16'hD001; exp_d[1] = 16'hD022; exp_d[2] = 16'hD803;
        tick; rd_offset_ll = 12'h001; rd_offset_hl = 12'h002; rd_offset_lh = 12'h003;
        rd_req = 3'b111; settle;
        for (int c = 0; c < 6; c++) begin
            checks++; if (rd_gnt !== exp_g[c % 3]) begin errors++; $display("FAIL rr_gnt%0d got %b exp %b", c, rd_gnt, exp_g[c % 3]); end
            checks++; if (ram_address !== exp_a[c % 3]) begin errors++; $display("FAIL rr_addr%0d got %h exp %h", c, ram_address, exp_a[c % 3]); end
            if (c > 0) begin
                checks++; if (rd_valid !== exp_g[(c - 1) % 3] || rd_data !== exp_d[(c - 1) % 3]) begin
                    errors++; $display("FAIL rr_ret%0d got %b/%h exp %b/%h", c, rd_valid, rd_data, exp_g[(c - 1) % 3], exp_d[(c - 1) % 3]);
                end
            end
            if (c < 5) begin tick; settle; end
        end
        tick; rd_req = 3'b000; settle;
        checks++; if (rd_valid !== 3'b100 || rd_data !== 16'hD803) begin errors++; $display("FAIL rr_last_ret got %b/%h exp 100/D803", rd_valid, rd_data); end
        checks++; if (rd_gnt !== 3'b000) begin errors++; $display("FAIL rr_idle_gnt got %b exp 000", rd_gnt); end
    endtask

    task automatic test_starvation;
        int k;
        logic exp_w;
        logic [11:0] rb_k [0:3];
        k = 0;
        tick; rd_offset_hl = 12'h004; rd_req = 3'b010;
        wr_req = 1'b1; wr_addr = 12'h100; wr_data = 16'h5000; settle;
        for (int j = 0; j < 20; j++) begin
            exp_w = (j != 8);
            checks++; if (wr_gnt !== exp_w || ram_wren !== exp_w) begin errors++; $display("FAIL stv_wr%0d got %b/%b exp %b", j, wr_gnt, ram_wren, exp_w); end
            checks++; if (rd_gnt !== ((j == 8) ? 3'b010 : 3'b000)) begin errors++; $display("FAIL stv_rd%0d got %b", j, rd_gnt); end
            if (exp_w) begin
                checks++; if (ram_address !== 12'(12'h100 + k) || ram_data !== 16'(16'h5000 + k)) begin
                    errors++; $display("FAIL stv_waddr%0d got %h/%h exp %h/%h", j, ram_address, ram_data, 12'(12'h100 + k), 16'(16'h5000 + k));
                end
            end else begin
                checks++; if (ram_address !== 12'h024) begin errors++; $display("FAIL stv_raddr got %h exp 024", ram_address); end
            end
            if (j == 9) begin
                checks++; if (rd_valid !== 3'b010 || rd_data !== 16'hD024) begin errors++; $display("FAIL stv_ret got %b/%h exp 010/D024", rd_valid, rd_data); end
            end else begin
                checks++; if (rd_valid !== 3'b000) begin errors++; $display("FAIL stv_noret%0d got %b exp 000", j, rd_valid); end
            end
            tick;
            if (exp_w) k++;
            wr_addr = 12'(12'h100 + k);
            wr_data = 16'(16'h5000 + k);
            if (j == 8) rd_req = 3'b000;
            if (j == 19) wr_req = 1'b0;
            settle;
        end
        rb_k[0] = 12'd0; rb_k[1] = 12'd7; rb_k[2] = 12'd8; rb_k[3] = 12'd18;
        for (int r = 0; r < 4; r++) begin
            tick; rd_offset_ll = 12'h100 + rb_k[r]; rd_req = 3'b001; settle;
            checks++; if (rd_gnt !== 3'b001) begin errors++; $display("FAIL rb_gnt%0d got %b exp 001", r, rd_gnt); end
            tick; rd_req = 3'b000; settle;
            checks++; if (rd_valid !== 3'b001 || rd_data !== (16'h5000 + {4'h0, rb_k[r]})) begin
                errors++; $display("FAIL rb_data%0d got %b/%h exp 001/%h", r, rd_valid, rd_data, 16'h5000 + {4'h0, rb_k[r]});
            end
        end
    endtask

    task automatic test_reset_inflight;
        logic [2:0] req2 [0:1];
        logic [2:0] exp2 [0:1];
        req2[0] = 3'b011; exp2[0] = 3'b001;
        req2[1] = 3'b110; exp2[1] = 3'b010;
        for (int s = 0; s < 2; s++) begin
            tick; rd_offset_hl = 12'h001; rd_req = 3'b010; settle;
            checks++; if (rd_gnt !== 3'b010) begin errors++; $display("FAIL inf_gnt%0d got %b exp 010", s, rd_gnt); end
            tick; rd_req = 3'b000; rst = 1'b1; settle;
            checks++; if (rd_valid !== 3'b000) begin errors++; $display("FAIL inf_valid_rst%0d got %b exp 000", s, rd_valid); end
            tick; rst = 1'b0; rd_offset_ll = 12'h002; rd_offset_hl = 12'h002; rd_offset_lh = 12'h002;
            rd_req = req2[s]; settle;
            checks++; if (rd_valid !== 3'b000) begin errors++; $display("FAIL inf_valid_post%0d got %b exp 000", s, rd_valid); end
            checks++; if (rd_gnt !== exp2[s]) begin errors++; $display("FAIL inf_ptr%0d got %b exp %b", s, rd_gnt, exp2[s]); end
            tick; rd_req = 3'b000; settle;
            checks++; if (rd_valid !== exp2[s]) begin errors++; $display("FAIL inf_ret%0d got %b exp %b", s, rd_valid, exp2[s]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = {4'hD, 12'(i)};
        test_reset;
        test_ll_read;
        test_lh_wrap;
        test_round_robin;
        test_starvation;
        test_reset_inflight;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/subband_ram_scheduler.md
# subband_ram_scheduler

Sequencer and arbiter for the shared 4096×16 single-port subband RAM that sits behind the 2-D wavelet stage and feeds the three context-encoder shift-register chains. It shares that RAM between one writer (wavelet transform) and three subband readers (LL, HL, LH). Writes have priority, with a starvation guard. Reads are granted round-robin, and each return is steered to the owning reader as a one-cycle valid strobe that serves directly as that chain's shift enable.

## Interface
- ADDR_W, 12, RAM address width
- DATA_W, 16, RAM word width
- LL_BASE, 12'd0, LL subband base address
- HL_BASE, 12'd32, HL subband base address
- LH_BASE, 12'd2048, LH subband base address
- STARVE_LIMIT, 8, consecutive write grants allowed while any read is pending (≥1)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous reset, active-high
- wr_req  in  1  writer requests a write this cycle
- wr_addr  in  ADDR_W  absolute write address
- wr_data  in  DATA_W  write data
- wr_gnt  out  1  write performed this cycle
- rd_req  in  3  read request, bit0 LL, bit1 HL, bit2 LH
- rd_offset_ll / rd_offset_hl / rd_offset_lh  in  ADDR_W each  offset within subband
- rd_gnt  out  3  one-hot read grant, combinational
- rd_valid  out  3  one-hot, high the cycle after the matching rd_gnt
- rd_data  out  DATA_W  equals ram_q; meaningful only while rd_valid≠0
- ram_address  out  ADDR_W  to RAM
- ram_data  out  DATA_W  to RAM, equals wr_data
- ram_wren  out  1  RAM write enable
- ram_q  in  DATA_W  RAM read data; address is registered in the RAM, so q is valid 1 cycle after the address

## Operation
- Transfer rule: request and grant are high in the same cycle. A requester holds req, address and data stable until granted.
- At most one grant per cycle across wr_gnt and rd_gnt.
- Write priority: wr_gnt = wr_req & ~force_read.
  - force_read = (starve_cnt == STARVE_LIMIT) & (rd_req ≠ 0).
- Read grant applies when no write is granted and rd_req ≠ 0. The winner is the first set bit searching from rr_ptr upward, modulo 3.
  - After a read grant, rr_ptr ← (granted index + 1) mod 3.
- starve_cnt (0..STARVE_LIMIT):
  - +1 on a write grant while rd_req ≠ 0.
  - Cleared on any read grant or when rd_req == 0.
  - Saturates at STARVE_LIMIT.
- Read address = base of the granted channel + its offset, truncated to ADDR_W. Wrap-around is modulo 4096 with no error.
- ram_wren = wr_gnt.
- ram_address selection:
  - write grant: wr_addr
  - read grant: computed read address
  - no grant: last issued address, held in a register so the RAM address port does not toggle.
- rd_valid ← rd_gnt, registered.
- rd_data passes ram_q through combinationally.
- A write in the same cycle as a read return is legal; the return uses the previous cycle's address.

## Timing
- Grant latency: 0 cycles (combinational from req).
- Read latency: rd_gnt at cycle N, then rd_valid and rd_data at N+1.
- Throughput: one RAM access per cycle. Back-to-back reads from one channel alone give rd_valid high every cycle.
- Values while rst=1:
  - wr_gnt=0, rd_gnt=0, ram_wren=0.
  - On the next edge: rd_valid=0, rr_ptr=0, starve_cnt=0, held address register=0.
- Reset asserted during a pending read (grant at N, rst at N+1): rd_valid is 0 at N+1 edge output. The in-flight return is dropped, not replayed.
- All three readers requesting continuously with no writes: grants cycle LL, HL, LH, LL, …
- Writer requesting continuously with one reader waiting: exactly STARVE_LIMIT write grants, then 1 read grant, repeating.

## Structure
- Package subband_ram_pkg holds:
  - channel indices CH_LL=0, CH_HL=1, CH_LH=2
  - base-address constants
  - ADDR_W and DATA_W defaults
- Sub-module rr_arbiter3: 3-way round-robin (req, enable, gnt, pointer update). The top level adds write priority, the starvation counter, address formation and the return pipeline.

## Test plan
- Reset then idle:
  - Required: all grants 0, ram_wren 0, rd_valid 0, ram_address 0 throughout.
- Single LL read at offset 12'h005:
  - Required: rd_gnt=3'b001 in the same cycle, ram_address=12'h005, and rd_valid=3'b001 next cycle with rd_data = preloaded word.
- LH read at offset 12'h805, i.e. 2048+2053:
  - Required: ram_address=12'h005 (wrap), data returned on rd_valid bit2.
- All three readers held high for 6 cycles, no writes:
  - Required: grant sequence 001, 010, 100, 001, 010, 100, with rd_valid lagging by 1.
- wr_req held 20 cycles with HL read pending, STARVE_LIMIT=8:
  - Required: writes in cycles 0–7, HL read in cycle 8, writes resume in cycle 9.
  - Required: write data at the written addresses reads back intact.
- rst pulsed 1 cycle after an HL grant:
  - Required: no rd_valid for that read, rr_ptr back to 0, so the next simultaneous LL+HL request grants LL.
